// File: rtl/lane_deskew_n.sv
// N-lane receive deskew: each lane is locked on a common alignment marker, the
// lock-time spread is measured, and all lane FIFOs are then drained in lockstep.
module lane_deskew_n #(
  parameter int               LANES    = 2,
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 8,
  parameter logic [WIDTH-1:0] MARKER   = 8'h4A,
  parameter int               MAX_SKEW = DEPTH - 2
) (
  input  logic                     fsm_clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [LANES*WIDTH-1:0]   lane_rx_in,
  input  logic [LANES-1:0]         lane_rx_valid,
  output logic [LANES*WIDTH-1:0]   lane_rx_out,
  output logic                     rx_valid_out,
  output logic                     rx_lanes_on,
  output logic                     deskew_error,
  output logic [$clog2(DEPTH)-1:0] skew_value
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_SKEW + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    ALIGNED = 2'd2,
    ERROR   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [LANES-1:0]       lock_q, lock_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          skew_q, skew_d;
  logic [PW-1:0]          wp_q [LANES];
  logic [PW-1:0]          wp_d [LANES];
  logic [PW-1:0]          rp_q [LANES];
  logic [PW-1:0]          rp_d [LANES];
  logic [WIDTH-1:0]       mem_q [LANES][DEPTH];
  logic [WIDTH-1:0]       mem_d [LANES][DEPTH];
  logic [LANES*WIDTH-1:0] out_q, out_d;
  logic                   vout_q, vout_d;
  logic                   on_q, on_d;
  logic                   err_q, err_d;

  logic [WIDTH-1:0]       sym  [LANES];
  logic [LANES*WIDTH-1:0] heads;
  logic [LANES-1:0]       mark, head_mark, empty, full, wr;
  logic                   pop, flush;

  always_comb begin
    heads = '0;
    for (int i = 0; i < LANES; i++) begin
      sym[i]                  = lane_rx_in[i*WIDTH +: WIDTH];
      mark[i]                 = (lane_rx_in[i*WIDTH +: WIDTH] == MARKER);
      heads[i*WIDTH +: WIDTH] = mem_q[i][rp_q[i][AW-1:0]];
      head_mark[i]            = (mem_q[i][rp_q[i][AW-1:0]] == MARKER);
      empty[i]                = (wp_q[i] == rp_q[i]);
      full[i]                 = (wp_q[i][AW] != rp_q[i][AW]) &&
                                (wp_q[i][AW-1:0] == rp_q[i][AW-1:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    skew_d  = skew_q;
    out_d   = out_q;
    vout_d  = 1'b0;
    wp_d    = wp_q;
    rp_d    = rp_q;
    mem_d   = mem_q;
    wr      = '0;
    pop     = 1'b0;
    flush   = 1'b0;

    case (state_q)
      IDLE: begin
        flush   = 1'b1;
        state_d = HUNT;
      end
      HUNT: begin
        // Unlocked lanes discard everything until their first marker.
        wr     = lane_rx_valid & (lock_q | mark);
        lock_d = lock_q | (lane_rx_valid & mark);
        if (|lock_d) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (|(wr & full)) begin
          state_d = ERROR;
        end else if (cnt_q > CW'(MAX_SKEW)) begin
          state_d = ERROR;
        end else if (&lock_d) begin
          state_d = ALIGNED;
          skew_d  = AW'(cnt_q);
        end else begin
          state_d = HUNT;
        end
      end
      ALIGNED: begin
        wr  = lane_rx_valid;
        pop = &(~empty);
        // A pop frees a slot, so a full FIFO may still accept a write that cycle.
        if ((|(wr & full & ~{LANES{pop}})) || (pop && (|head_mark) && !(&head_mark))) begin
          state_d = ERROR;
          wr      = '0;
          pop     = 1'b0;
        end else if (pop) begin
          out_d  = heads;
          vout_d = 1'b1;
        end else begin
          state_d = ALIGNED;
        end
      end
      ERROR: begin
        flush   = 1'b1;
        state_d = HUNT;
      end
      default: begin
        flush   = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (!enable) begin
      state_d = IDLE;
      flush   = 1'b1;
      wr      = '0;
      pop     = 1'b0;
      vout_d  = 1'b0;
      out_d   = '0;
    end

    for (int i = 0; i < LANES; i++) begin
      if (wr[i] && (!full[i] || pop)) begin
        mem_d[i][wp_q[i][AW-1:0]] = sym[i];
        wp_d[i]                   = wp_q[i] + PW'(1);
      end
      if (pop) begin
        rp_d[i] = rp_q[i] + PW'(1);
      end
    end

    if (flush) begin
      lock_d = '0;
      for (int i = 0; i < LANES; i++) begin
        wp_d[i] = '0;
        rp_d[i] = '0;
      end
    end
    if (state_d != HUNT) begin
      cnt_d = '0;
    end
    if (state_d != ALIGNED) begin
      skew_d = '0;
    end
    on_d  = (state_d == ALIGNED);
    err_d = (state_d == ERROR);
  end

  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      cnt_q   <= '0;
      skew_q  <= '0;
      out_q   <= '0;
      vout_q  <= 1'b0;
      on_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      skew_q  <= skew_d;
      out_q   <= out_d;
      vout_q  <= vout_d;
      on_q    <= on_d;
      err_q   <= err_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      mem_q   <= mem_d;
    end
  end

  assign lane_rx_out  = out_q;
  assign rx_valid_out = vout_q;
  assign rx_lanes_on  = on_q;
  assign deskew_error = err_q;
  assign skew_value   = skew_q;

endmodule

// File: tb/tb_lane_deskew_n.sv
// Randomized bench for lane_deskew_n: delayed/stalled copies of one marker
// stream are checked each cycle against a queue-based reference model.
module tb_lane_deskew_n;
  localparam int               LANES    = 2;
  localparam int               WIDTH    = 8;
  localparam int               DEPTH    = 8;
  localparam int               MAX_SKEW = DEPTH - 2;
  localparam int               AW       = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] MARKER   = 8'h4A;
  localparam int M_IDLE = 0, M_HUNT = 1, M_AL = 2, M_ERR = 3;
  localparam int NSC = 40, NCYC = 60;

  logic                   fsm_clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   enable = 1'b0;
  logic [LANES*WIDTH-1:0] lane_rx_in = '0;
  logic [LANES-1:0]       lane_rx_valid = '0;
  logic [LANES*WIDTH-1:0] lane_rx_out;
  logic                   rx_valid_out, rx_lanes_on, deskew_error;
  logic [AW-1:0]          skew_value;

  lane_deskew_n #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH),
                  .MARKER(MARKER), .MAX_SKEW(MAX_SKEW)) dut (
    .fsm_clk(fsm_clk), .rst(rst), .enable(enable),
    .lane_rx_in(lane_rx_in), .lane_rx_valid(lane_rx_valid),
    .lane_rx_out(lane_rx_out), .rx_valid_out(rx_valid_out),
    .rx_lanes_on(rx_lanes_on), .deskew_error(deskew_error),
    .skew_value(skew_value)
  );

  always #5 fsm_clk = ~fsm_clk;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue per lane plus marker lock timestamps.
  typedef logic [WIDTH-1:0] sym_q_t [$];
  sym_q_t                 fq [LANES];
  bit                     locked [LANES];
  int                     t_first, mode, cyc;
  logic                   e_vout, e_on, e_err;
  logic [AW-1:0]          e_skew;
  logic [LANES*WIDTH-1:0] e_data;

  task automatic model_clear();
    for (int i = 0; i < LANES; i++) begin
      fq[i].delete();
      locked[i] = 1'b0;
    end
    t_first = -1;
  endtask

  task automatic model_reset();
    model_clear();
    mode = M_IDLE;
    e_vout = 1'b0; e_on = 1'b0; e_err = 1'b0; e_skew = '0; e_data = '0;
  endtask

  task automatic model_step(input logic en, input logic [LANES-1:0] v, input logic [LANES*WIDTH-1:0] d);
    logic [WIDTH-1:0] s;
    bit ovf, all_lk, pp;
    int nm;
    ovf = 1'b0; all_lk = 1'b1; pp = 1'b1; nm = 0;
    e_vout = 1'b0;
    if (!en) begin
      model_clear();
      mode = M_IDLE;
      e_data = '0;
    end else begin
      case (mode)
        M_IDLE, M_ERR: begin
          model_clear();
          mode = M_HUNT;
        end
        M_HUNT: begin
          for (int i = 0; i < LANES; i++) begin
            s = d[i*WIDTH +: WIDTH];
            if (v[i] && (locked[i] || s == MARKER)) begin
              if (fq[i].size() >= DEPTH) ovf = 1'b1;
              else fq[i].push_back(s);
              if (!locked[i]) begin
                locked[i] = 1'b1;
                if (t_first < 0) t_first = cyc;
              end
            end
            if (!locked[i]) all_lk = 1'b0;
          end
          if (ovf || (t_first >= 0 && (cyc - t_first) > MAX_SKEW)) mode = M_ERR;
          else if (all_lk) begin
            mode = M_AL;
            e_skew = AW'(cyc - t_first);
          end
        end
        M_AL: begin
          for (int i = 0; i < LANES; i++) if (fq[i].size() == 0) pp = 1'b0;
          if (pp) for (int i = 0; i < LANES; i++) if (fq[i][0] == MARKER) nm++;
          for (int i = 0; i < LANES; i++)
            if (v[i] && fq[i].size() >= DEPTH && !pp) ovf = 1'b1;
          if (ovf || (pp && nm > 0 && nm < LANES)) mode = M_ERR;
          else begin
            if (pp) begin
              for (int i = 0; i < LANES; i++) e_data[i*WIDTH +: WIDTH] = fq[i].pop_front();
              e_vout = 1'b1;
            end
            for (int i = 0; i < LANES; i++) if (v[i]) fq[i].push_back(d[i*WIDTH +: WIDTH]);
          end
        end
        default: mode = M_IDLE;
      endcase
    end
    e_on  = (mode == M_AL);
    e_err = (mode == M_ERR);
    if (mode != M_AL) e_skew = '0;
    cyc++;
  endtask

  task automatic compare_all();
    check_val("rx_valid_out", 64'(rx_valid_out), 64'(e_vout));
    check_val("rx_lanes_on",  64'(rx_lanes_on),  64'(e_on));
    check_val("deskew_error", 64'(deskew_error), 64'(e_err));
    check_val("skew_value",   64'(skew_value),   64'(e_skew));
    check_val("lane_rx_out",  64'(lane_rx_out),  64'(e_data));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, 64'(rx_valid_out), 64'd0);
    check_val({tag, "_on"},    64'(rx_lanes_on),  64'd0);
    check_val({tag, "_err"},   64'(deskew_error), 64'd0);
    check_val({tag, "_skew"},  64'(skew_value),   64'd0);
    check_val({tag, "_data"},  64'(lane_rx_out),  64'd0);
  endtask

  task automatic tick();
    model_step(enable, lane_rx_valid, lane_rx_in);
    @(posedge fsm_clk);
    #1;
    compare_all();
  endtask

  logic [WIDTH-1:0] src [64];
  int rd [LANES];
  int dly [LANES];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int smode, ls_lane, ls_start, ls_len, ed_at, ed_len, rst_at, ev;
    bit cstall, stall;
    logic [WIDTH-1:0] r;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge fsm_clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    for (int sc = 0; sc < NSC; sc++) begin
      for (int k = 0; k < 64; k++) begin
        if (k % 12 == 0) src[k] = MARKER;
        else begin
          r = WIDTH'($urandom);
          if (r == MARKER) r = r ^ WIDTH'(1);
          src[k] = r;
        end
      end
      for (int i = 0; i < LANES; i++) begin
        rd[i] = 0;
        dly[i] = (sc < 7) ? 0 : $urandom_range(0, 1);
      end
      smode = (sc < 7) ? 0 : $urandom_range(0, 3);
      ls_lane = $urandom_range(0, LANES - 1);
      ls_start = $urandom_range(15, 30);
      ls_len = $urandom_range(9, 12);
      ev = (sc < 7) ? 0 : $urandom_range(0, 3);
      ed_at = -100; ed_len = 0; rst_at = -100;
      case (sc)
        1: dly[1] = 3;
        2: dly[1] = 7;
        3: begin smode = 2; ls_lane = 1; ls_start = 20; ls_len = 9; end
        4: smode = 1;
        5: begin ed_at = 30; ed_len = 2; end
        6: rst_at = 30;
        default: begin
          dly[$urandom_range(0, LANES - 1)] += $urandom_range(0, 8);
          if (ev == 1) begin ed_at = $urandom_range(20, 45); ed_len = $urandom_range(1, 3); end
          if (ev == 2) rst_at = $urandom_range(20, 45);
        end
      endcase

      // Idle gap so every scenario starts from a flushed block.
      enable = 1'b0; lane_rx_valid = '0; lane_rx_in = '0;
      repeat (2) tick();

      for (int t = 0; t < NCYC; t++) begin
        enable = !(t >= ed_at && t < ed_at + ed_len);
        lane_rx_valid = '0;
        lane_rx_in = '0;
        cstall = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < LANES; i++) begin
          case (smode)
            1: stall = ($urandom_range(0, 19) == 0);
            2: stall = (i == ls_lane) && (t >= ls_start) && (t < ls_start + ls_len);
            3: stall = cstall;
            default: stall = 1'b0;
          endcase
          if (!stall && (rd[i] + dly[i] + 1 <= t)) begin
            lane_rx_valid[i] = 1'b1;
            lane_rx_in[i*WIDTH +: WIDTH] = src[rd[i]];
            rd[i]++;
          end
        end
        if (t == rst_at) begin
          rst = 1'b0;
          #1;
          model_reset();
          check_zero("async_rst");
          @(posedge fsm_clk);
          #1;
          check_zero("held_rst");
          rst = 1'b1;
        end else begin
          tick();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
